// File: rtl/key_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner_if
// Brief    : Raw button/switch inputs and conditioned key outputs of the lock front end
// Revision : 1.0
// ============================================================================
interface key_conditioner_if;
    logic       KeyRaw1;
    logic       KeyRaw2;
    logic [3:0] PasswordRaw;
    logic       Key1;
    logic       Key2;
    logic [3:0] Password;
    logic       Collision;

    modport master (
        output KeyRaw1, KeyRaw2, PasswordRaw,
        input  Key1, Key2, Password, Collision
    );

    modport slave (
        input  KeyRaw1, KeyRaw2, PasswordRaw,
        output Key1, Key2, Password, Collision
    );
endinterface
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Brief    : Synchronizes and debounces two buttons into single press pulses with captured switch value
// Revision : 1.0
// ============================================================================
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic        Clk,
    input  wire logic        Reset_n,
    key_conditioner_if.slave bus
);

    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0] r_key_s1;
    logic [1:0] r_key_s2;
    logic [3:0] r_pw_s1;
    logic [3:0] r_pw_s2;
    logic [1:0] w_accept;
    logic       r_key1;
    logic       r_key2;
    logic       r_coll;
    logic [3:0] r_pw;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key_s1 <= 2'b00;
            r_key_s2 <= 2'b00;
            r_pw_s1  <= 4'b0000;
            r_pw_s2  <= 4'b0000;
        end else begin
            r_key_s1 <= {bus.KeyRaw2, bus.KeyRaw1};
            r_key_s2 <= r_key_s1;
            r_pw_s1  <= bus.PasswordRaw;
            r_pw_s2  <= r_pw_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            state_t               r_state;
            state_t               w_state_nxt;
            logic [c_cnt_w-1:0]   r_cnt;
            logic [c_cnt_w-1:0]   w_cnt_nxt;
            logic                 w_acc;
            logic                 w_s;

            assign w_s = r_key_s2[gi];

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            // A level change must persist through the whole count; any relapse aborts it.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_acc       = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            w_state_nxt = ST_PRESS_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!w_s) begin
                            w_state_nxt = ST_IDLE;
                        end else if (r_cnt == c_cnt_max) begin
                            w_state_nxt = ST_HELD;
                            w_acc       = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (!w_s) begin
                            w_state_nxt = ST_RELEASE_WAIT;
                            w_cnt_nxt   = '0;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (w_s) begin
                            w_state_nxt = ST_HELD;
                        end else if (r_cnt == c_cnt_max) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            assign w_accept[gi] = w_acc;
        end
    endgenerate

    // Simultaneous accepts are ambiguous for the lock, so they only raise Collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key1 <= 1'b0;
            r_key2 <= 1'b0;
            r_coll <= 1'b0;
            r_pw   <= 4'b0000;
        end else begin
            r_key1 <= w_accept[0] & ~w_accept[1];
            r_key2 <= w_accept[1] & ~w_accept[0];
            r_coll <= w_accept[0] &  w_accept[1];
            if (w_accept[0] ^ w_accept[1]) begin
                r_pw <= r_pw_s2;
            end
        end
    end

    assign bus.Key1      = r_key1;
    assign bus.Key2      = r_key2;
    assign bus.Collision = r_coll;
    assign bus.Password  = r_pw;

endmodule
`default_nettype wire
